// File: rtl/mcpu_pkg.sv
// Shared constants for the multi-cycle MIPS-subset core: ALU commands,
// opcode/funct encodings and the sequencer state type.
package mcpu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // ST_TRAP is only reachable when MULTICYCLE_CPU_TRAP_EN is defined.
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU with 3-bit command. Carry and overflow are produced
// for ADD and SUB only; every other command reports them as 0.
module mcpu_alu
  import mcpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cmd,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carryout,
  output logic             overflow
);

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // Select the operation; flags derive from the selected result
  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (cmd)
      ALU_ADD: begin
        result   = add_w[WIDTH-1:0];
        carryout = add_w[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = sub_w[WIDTH-1:0];
        carryout = sub_w[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = WIDTH'($signed(a) < $signed(b));
      ALU_AND:  result = a & b;
      ALU_NAND: result = ~(a & b);
      ALU_NOR:  result = ~(a | b);
      ALU_OR:   result = a | b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer, inline
// decoder and 32-entry register file, external data memory over req/ack.
// Optional: define MULTICYCLE_CPU_TRAP_EN to halt in TRAP on unknown opcodes;
// otherwise unknown instructions retire as NOPs.
module multicycle_cpu
  import mcpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] pc,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             retire,
  output logic [WIDTH-1:0] Op_end_result,
  output logic             Alu_zero,
  output logic             Alu_carryout,
  output logic             Alu_overflow
);

  // Low 28 bits of a J/JAL target come from the instruction; for narrow
  // datapaths the cast truncates the mask so the target is simply cut off.
  localparam logic [WIDTH-1:0] LOW28 = WIDTH'(28'hFFF_FFFF);

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d, next_pc_q, next_pc_d;
  logic [WIDTH-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d, op_end_q, op_end_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic             instr_ready_q, instr_ready_d, retire_q, retire_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] regs_q [32];

  logic             rf_we;
  logic [4:0]       dest;
  logic [WIDTH-1:0] imm_se, imm_ze, pc_plus4, branch_target, jump_target;
  logic [WIDTH-1:0] alu_b, alu_result;
  logic [2:0]       alu_cmd;
  logic             alu_zero, alu_carry, alu_ovf, has_flags;
  logic             is_alu, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;

  assign imm_se        = WIDTH'($signed(instr_q[15:0]));
  assign imm_ze        = WIDTH'(instr_q[15:0]);
  assign pc_plus4      = pc_q + WIDTH'(4);
  assign branch_target = pc_plus4 + {imm_se[WIDTH-3:0], 2'b00};
  assign jump_target   = (pc_plus4 & ~LOW28) | (WIDTH'({instr_q[25:0], 2'b00}) & LOW28);

  // Decode the latched instruction into class flags and ALU controls
  always_comb begin
    is_alu = 1'b0; is_jr = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0;
    has_flags = 1'b0;
    alu_cmd   = ALU_ADD;
    alu_b     = imm_se;
    dest      = instr_q[20:16];
    case (instr_q[31:26])
      OP_RTYPE: begin
        alu_b = rt_val_q;
        dest  = instr_q[15:11];
        is_alu = 1'b1;
        case (instr_q[5:0])
          FN_ADD: has_flags = 1'b1;
          FN_SUB: begin alu_cmd = ALU_SUB; has_flags = 1'b1; end
          FN_AND: alu_cmd = ALU_AND;
          FN_OR:  alu_cmd = ALU_OR;
          FN_XOR: alu_cmd = ALU_XOR;
          FN_NOR: alu_cmd = ALU_NOR;
          FN_SLT: alu_cmd = ALU_SLT;
          FN_JR:  begin is_alu = 1'b0; is_jr = 1'b1; end
          default: is_alu = 1'b0;
        endcase
      end
      OP_ADDI: begin is_alu = 1'b1; has_flags = 1'b1; end
      OP_XORI: begin is_alu = 1'b1; alu_cmd = ALU_XOR; alu_b = imm_ze; end
      OP_LW:   is_lw = 1'b1;
      OP_SW:   is_sw = 1'b1;
      OP_BEQ:  begin is_beq = 1'b1; alu_cmd = ALU_SUB; alu_b = rt_val_q; end
      OP_BNE:  begin is_bne = 1'b1; alu_cmd = ALU_SUB; alu_b = rt_val_q; end
      OP_J:    is_j = 1'b1;
      OP_JAL:  begin is_jal = 1'b1; dest = 5'd31; end
      default: ;
    endcase
  end

  mcpu_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (rs_val_q),
    .b        (alu_b),
    .cmd      (alu_cmd),
    .result   (alu_result),
    .zero     (alu_zero),
    .carryout (alu_carry),
    .overflow (alu_ovf)
  );

  // Sequencer next-state and registered-output computation
  always_comb begin
    state_d = state_q;   instr_d = instr_q;     pc_d = pc_q;
    next_pc_d = next_pc_q; rs_val_d = rs_val_q; rt_val_d = rt_val_q;
    wb_data_d = wb_data_q; op_end_d = op_end_q;
    mem_req_d = mem_req_q; mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;
    zero_d = zero_q; carry_d = carry_q; ovf_d = ovf_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        rs_val_d = regs_q[instr_q[25:21]];
        rt_val_d = regs_q[instr_q[20:16]];
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        zero_d    = alu_zero;
        carry_d   = alu_carry & has_flags;
        ovf_d     = alu_ovf & has_flags;
        next_pc_d = pc_plus4;
        if (is_lw || is_sw) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_sw;
          mem_addr_d  = alu_result;
          mem_wdata_d = rt_val_q;
          state_d     = ST_MEM;
        end else if (is_beq || is_bne || is_j || is_jr) begin
          retire_d = 1'b1;
          op_end_d = alu_result;
          state_d  = ST_FETCH;
          if ((is_beq && alu_zero) || (is_bne && !alu_zero)) pc_d = branch_target;
          else if (is_j)  pc_d = jump_target;
          else if (is_jr) pc_d = rs_val_q;
          else            pc_d = pc_plus4;
        end else if (is_alu) begin
          wb_data_d = alu_result;
          state_d   = ST_WB;
        end else if (is_jal) begin
          wb_data_d = pc_plus4;
          next_pc_d = jump_target;
          state_d   = ST_WB;
        end else begin
`ifdef MULTICYCLE_CPU_TRAP_EN
          state_d  = ST_TRAP;
`else
          retire_d = 1'b1;
          op_end_d = alu_result;
          pc_d     = pc_plus4;
          state_d  = ST_FETCH;
`endif
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            retire_d = 1'b1;
            op_end_d = mem_addr_q;
            pc_d     = next_pc_q;
            state_d  = ST_FETCH;
          end else begin
            wb_data_d = mem_rdata;
            state_d   = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we    = (dest != 5'd0);
        retire_d = 1'b1;
        op_end_d = wb_data_q;
        pc_d     = next_pc_q;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    instr_ready_d = (state_d == ST_FETCH);
  end

  // State, outputs and register file update; reset discards any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;   instr_q <= '0;    pc_q <= RESET_PC;
      next_pc_q <= '0;       rs_val_q <= '0;   rt_val_q <= '0;
      wb_data_q <= '0;       op_end_q <= '0;
      mem_req_q <= 1'b0;     mem_we_q <= 1'b0;
      mem_addr_q <= '0;      mem_wdata_q <= '0;
      zero_q <= 1'b0;        carry_q <= 1'b0;  ovf_q <= 1'b0;
      retire_q <= 1'b0;      instr_ready_q <= 1'b1;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;    instr_q <= instr_d;   pc_q <= pc_d;
      next_pc_q <= next_pc_d; rs_val_q <= rs_val_d; rt_val_q <= rt_val_d;
      wb_data_q <= wb_data_d; op_end_q <= op_end_d;
      mem_req_q <= mem_req_d; mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      zero_q <= zero_d;      carry_q <= carry_d;   ovf_q <= ovf_d;
      retire_q <= retire_d;  instr_ready_q <= instr_ready_d;
      if (rf_we) regs_q[dest] <= wb_data_q;
    end
  end

  assign instr_ready   = instr_ready_q;
  assign pc            = pc_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign retire        = retire_q;
  assign Op_end_result = op_end_q;
  assign Alu_zero      = zero_q;
  assign Alu_carryout  = carry_q;
  assign Alu_overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: hand-computed results, latencies, pc
// updates, memory handshake and reset/trap behaviour.
module tb_multicycle_cpu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, instr_valid, instr_ready, mem_req, mem_we, mem_ack, retire;
  logic          Alu_zero, Alu_carryout, Alu_overflow;
  logic [31:0]   instr;
  logic [W-1:0]  pc, mem_addr, mem_wdata, mem_rdata, Op_end_result;

  int            vectors = 0;
  int            miscompares = 0;
  logic [31:0]   dmem [16];
  int            lat, mreq_cycles;
  logic [W-1:0]  last_addr, last_wdata;
  logic          last_we;

  always #5 clk = ~clk;

  multicycle_cpu #(.WIDTH(W), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .retire(retire),
    .Op_end_result(Op_end_result), .Alu_zero(Alu_zero), .Alu_carryout(Alu_carryout),
    .Alu_overflow(Alu_overflow)
  );

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Issue one instruction, serve its memory access after 'waits' idle cycles,
  // and measure cycles from the accept edge to the retire pulse.
  task automatic run(input logic [31:0] ins, input int waits);
    int wcnt;
    int guard;
    wcnt = 0; guard = 0; lat = -1; mreq_cycles = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        mreq_cycles++;
        if (wcnt >= waits) begin
          mem_ack = 1'b1;
          last_addr = mem_addr; last_we = mem_we; last_wdata = mem_wdata;
          mem_rdata = dmem[mem_addr[5:2]];
          if (mem_we) dmem[mem_addr[5:2]] = mem_wdata;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (retire === 1'b1) begin lat = c; break; end
    end
    if (lat < 0) begin miscompares++; $display("FAIL retire_timeout instr %08h: no retire within 60 cycles, required a retire pulse", ins); end
    $display("instr %08h -> pc %08h lat %0d result %08h", ins, pc, lat, Op_end_result);
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", instr_ready); end
    vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL reset_retire got %b want 0", retire); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_memreq got %b want 0", mem_req); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 00000000", pc); end
    vectors++; if (Op_end_result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", Op_end_result); end
    vectors++; if ({Alu_zero, Alu_carryout, Alu_overflow} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {Alu_zero, Alu_carryout, Alu_overflow}); end
  endtask

  task automatic test_add();
    run(i_ins(6'h08, 5'd0, 5'd1, 16'd5), 0);
    vectors++; if (Op_end_result !== 32'd5) begin miscompares++; $display("FAIL addi_r1 got %h want 00000005", Op_end_result); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL addi_latency got %0d want 3", lat); end
    run(i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD), 0);
    vectors++; if (Op_end_result !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL addi_neg got %h want fffffffd", Op_end_result); end
    run(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 0);
    vectors++; if (Op_end_result !== 32'd2) begin miscompares++; $display("FAIL add_r3 got %h want 00000002", Op_end_result); end
    vectors++; if (Alu_carryout !== 1'b1) begin miscompares++; $display("FAIL add_carry got %b want 1", Alu_carryout); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL add_latency got %0d want 3", lat); end
    vectors++; if (pc !== 32'hC) begin miscompares++; $display("FAIL add_pc got %h want 0000000c", pc); end
  endtask

  task automatic test_overflow();
    dmem[0] = 32'h7FFFFFFF;
    run(i_ins(6'h23, 5'd0, 5'd1, 16'd0), 0);
    vectors++; if (Op_end_result !== 32'h7FFFFFFF) begin miscompares++; $display("FAIL lw_r1 got %h want 7fffffff", Op_end_result); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL lw_latency got %0d want 4", lat); end
    run(i_ins(6'h08, 5'd1, 5'd1, 16'd1), 0);
    vectors++; if (Op_end_result !== 32'h80000000) begin miscompares++; $display("FAIL ovf_result got %h want 80000000", Op_end_result); end
    vectors++; if (Alu_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", Alu_overflow); end
    vectors++; if (Alu_carryout !== 1'b0) begin miscompares++; $display("FAIL ovf_carry got %b want 0", Alu_carryout); end
  endtask

  task automatic test_alu_ops();
    run(i_ins(6'h0E, 5'd2, 5'd7, 16'h8000), 0);
    vectors++; if (Op_end_result !== 32'hFFFF7FFD) begin miscompares++; $display("FAIL xori_zext got %h want ffff7ffd", Op_end_result); end
    run(r_ins(5'd2, 5'd3, 5'd8, 6'h2A), 0);
    vectors++; if (Op_end_result !== 32'd1) begin miscompares++; $display("FAIL slt_signed got %h want 00000001", Op_end_result); end
    run(r_ins(5'd1, 5'd2, 5'd9, 6'h22), 0);
    vectors++; if (Op_end_result !== 32'h80000003) begin miscompares++; $display("FAIL sub_result got %h want 80000003", Op_end_result); end
    vectors++; if ({Alu_carryout, Alu_overflow} !== 2'b00) begin miscompares++; $display("FAIL sub_flags got %b want 00", {Alu_carryout, Alu_overflow}); end
    run(r_ins(5'd0, 5'd0, 5'd10, 6'h27), 0);
    vectors++; if (Op_end_result !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL nor_result got %h want ffffffff", Op_end_result); end
  endtask

  task automatic test_mem();
    run(i_ins(6'h2B, 5'd0, 5'd1, 16'd8), 3);
    vectors++; if (mreq_cycles !== 4) begin miscompares++; $display("FAIL sw_req_cycles got %0d want 4", mreq_cycles); end
    vectors++; if (last_addr !== 32'd8) begin miscompares++; $display("FAIL sw_addr got %h want 00000008", last_addr); end
    vectors++; if ({last_we, last_wdata} !== {1'b1, 32'h80000000}) begin miscompares++; $display("FAIL sw_we_data got %b/%h want 1/80000000", last_we, last_wdata); end
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL sw_latency got %0d want 6", lat); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sw_req_drop got %b want 0", mem_req); end
    run(i_ins(6'h23, 5'd0, 5'd4, 16'd8), 1);
    vectors++; if (Op_end_result !== 32'h80000000) begin miscompares++; $display("FAIL lw_r4 got %h want 80000000", Op_end_result); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL lw_wait_latency got %0d want 5", lat); end
    run(r_ins(5'd4, 5'd0, 5'd5, 6'h25), 0);
    vectors++; if (Op_end_result !== 32'h80000000) begin miscompares++; $display("FAIL r4_readback got %h want 80000000", Op_end_result); end
  endtask

  task automatic test_branch();
    run(j_ins(6'h02, 26'd4), 0);
    vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL j_pc got %h want 00000010", pc); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL j_latency got %0d want 2", lat); end
    run(i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF), 0);
    vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL beq_taken_pc got %h want 00000010", pc); end
    vectors++; if (Alu_zero !== 1'b1) begin miscompares++; $display("FAIL beq_zero got %b want 1", Alu_zero); end
    run(i_ins(6'h05, 5'd0, 5'd0, 16'd5), 0);
    vectors++; if (pc !== 32'h14) begin miscompares++; $display("FAIL bne_fall_pc got %h want 00000014", pc); end
    run(j_ins(6'h03, 26'h40), 0);
    vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL jal_pc got %h want 00000100", pc); end
    vectors++; if (Op_end_result !== 32'h18) begin miscompares++; $display("FAIL jal_link got %h want 00000018", Op_end_result); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL jal_latency got %0d want 3", lat); end
    run(r_ins(5'd31, 5'd0, 5'd6, 6'h25), 0);
    vectors++; if (Op_end_result !== 32'h18) begin miscompares++; $display("FAIL r31_readback got %h want 00000018", Op_end_result); end
    run(r_ins(5'd31, 5'd0, 5'd0, 6'h08), 0);
    vectors++; if (pc !== 32'h18) begin miscompares++; $display("FAIL jr_pc got %h want 00000018", pc); end
    run(i_ins(6'h05, 5'd1, 5'd0, 16'd2), 0);
    vectors++; if (pc !== 32'h24) begin miscompares++; $display("FAIL bne_taken_pc got %h want 00000024", pc); end
  endtask

  task automatic test_r0_and_idle();
    run(i_ins(6'h08, 5'd0, 5'd0, 16'd7), 0);
    run(r_ins(5'd0, 5'd0, 5'd6, 6'h20), 0);
    vectors++; if (Op_end_result !== 32'h0) begin miscompares++; $display("FAIL r0_reads_zero got %h want 00000000", Op_end_result); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if ({instr_ready, retire} !== 2'b10) begin miscompares++; $display("FAIL idle_cycle%0d ready/retire got %b want 10", i, {instr_ready, retire}); end
    end
    vectors++; if (pc !== 32'h2C) begin miscompares++; $display("FAIL idle_pc got %h want 0000002c", pc); end
  endtask

  task automatic test_unknown();
`ifdef MULTICYCLE_CPU_TRAP_EN
    logic seen_retire;
    seen_retire = 1'b0;
    instr = 32'hFC000000; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (retire === 1'b1) seen_retire = 1'b1;
    end
    $display("instr fc000000 -> trap check, pc %08h", pc);
    vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL trap_ready got %b want 0", instr_ready); end
    vectors++; if (seen_retire !== 1'b0) begin miscompares++; $display("FAIL trap_retire got %b want 0", seen_retire); end
    vectors++; if (pc !== 32'h2C) begin miscompares++; $display("FAIL trap_pc got %h want 0000002c", pc); end
`else
    run(32'hFC000000, 0);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL nop_latency got %0d want 2", lat); end
    vectors++; if (pc !== 32'h30) begin miscompares++; $display("FAIL nop_pc got %h want 00000030", pc); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    int guard;
    do_reset();
    run(i_ins(6'h08, 5'd0, 5'd4, 16'd9), 0);
    guard = 0;
    instr = i_ins(6'h23, 5'd0, 5'd4, 16'd8); instr_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    while (mem_req !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_mem_req got %b want 1", mem_req); end
    reset = 1'b1;
    @(posedge clk); #1;
    $display("reset during MEM -> mem_req %b pc %08h", mem_req, pc);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_reset_req got %b want 0", mem_req); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL mid_reset_pc got %h want 00000000", pc); end
    vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready got %b want 1", instr_ready); end
    reset = 1'b0;
    run(r_ins(5'd4, 5'd0, 5'd5, 6'h25), 0);
    vectors++; if (Op_end_result !== 32'h0) begin miscompares++; $display("FAIL reg_cleared got %h want 00000000", Op_end_result); end
    vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL post_reset_pc got %h want 00000004", pc); end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0; mem_rdata = '0;
    last_addr = '0; last_wdata = '0; last_we = 1'b0;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    test_reset();
    test_add();
    test_overflow();
    test_alu_ops();
    test_mem();
    test_branch();
    test_r0_and_idle();
    test_unknown();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
